// File: rtl/half_cycle_xfer_arb.sv
// ============================================================================
// Module   : half_cycle_xfer_arb
// Function : Round-robin arbiter feeding a half-cycle transfer path. A posedge
//            launch register drives a negedge capture register. The captured
//            word and its source index are presented on a posedge-registered
//            valid/ready output. A 16-bit wrapping counter tracks completed
//            output handshakes.
// Options  : HCXA_PARITY_EN - carry even parity across the half-cycle path and
//            flag a mismatch on out_perr (tied 0 when undefined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_cycle_xfer_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready,
    output logic                 out_perr,
    output logic [15:0]          xfer_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   rr_ptr_q;
    logic [DW-1:0]   launch_q;
    logic [SW-1:0]   launch_src_q;
    logic [DW-1:0]   cap_q;
    logic [SW-1:0]   cap_src_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [SW-1:0]   out_src_q;
    logic [15:0]     xfer_cnt_q;

    logic            grant_any;
    logic [SW-1:0]   grant_idx;
    logic [DW-1:0]   grant_data;
    logic            accept;
    logic            grant;
    logic [SW-1:0]   rr_ptr_d;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [SW-1:0] idx;
        idx        = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = SW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Winner's data word, selected with constant slices.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (SW'(k) == grant_idx) begin
                grant_data = req_data[k*DW +: DW];
            end
        end
    end

    // Accept window; reset gates req_ready so nothing is accepted while held.
    assign accept    = (state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready);
    assign grant     = accept & grant_any & rst_n;
    assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
    assign rr_ptr_d  = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef HCXA_PARITY_EN
    logic launch_par_q;
    logic cap_par_q;
    logic out_perr_q;
    assign out_perr = out_perr_q;
`else
    assign out_perr = 1'b0;
`endif

    // Posedge side: sequencer FSM, launch register, output register, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            launch_q     <= '0;
            launch_src_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            xfer_cnt_q   <= '0;
`ifdef HCXA_PARITY_EN
            launch_par_q <= 1'b0;
            out_perr_q   <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (grant) begin
                launch_q     <= grant_data;
                launch_src_q <= grant_idx;
                rr_ptr_q     <= rr_ptr_d;
`ifdef HCXA_PARITY_EN
                launch_par_q <= ^grant_data;
`endif
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    out_data_q  <= cap_q;
                    out_src_q   <= cap_src_q;
                    out_valid_q <= 1'b1;
`ifdef HCXA_PARITY_EN
                    out_perr_q  <= (^cap_q) != cap_par_q;
`endif
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef HCXA_PARITY_EN
                        out_perr_q  <= 1'b0;
`endif
                        state_q     <= grant ? ST_LAUNCH : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Negedge side: capture the launched word only during a LAUNCH cycle.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            cap_src_q <= '0;
`ifdef HCXA_PARITY_EN
            cap_par_q <= 1'b0;
`endif
        end else if (state_q == ST_LAUNCH) begin
            cap_q     <= launch_q;
            cap_src_q <= launch_src_q;
`ifdef HCXA_PARITY_EN
            cap_par_q <= launch_par_q;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_half_cycle_xfer_arb.sv
// ============================================================================
// Module   : tb_half_cycle_xfer_arb
// Function : Table-driven bench for half_cycle_xfer_arb plus directed
//            sequences for asynchronous reset and reset during LAUNCH.
//            With HCXA_PARITY_EN defined, also exercises the parity flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_half_cycle_xfer_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        out_perr;
    logic [15:0] xfer_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    half_cycle_xfer_arb #(.NREQ(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .out_perr  (out_perr),
        .xfer_cnt  (xfer_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: req_ready checked before the edge, registered
    // outputs checked 1 time unit after it.
    typedef struct {
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        ordy;
        logic [3:0]  ex_rdy;
        logic        ex_ov;
        logic [7:0]  ex_data;
        logic [1:0]  ex_src;
        logic        ex_busy;
        logic [15:0] ex_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        // single transfer from requester 2
        vecs[0]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0};
        vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b1, 16'd0};
        vecs[2]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd1};
        // all four requesting continuously; pointer starts at 3 and wraps
        vecs[3]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1, 16'd1};
        vecs[4]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd1};
        vecs[5]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1, 16'd2};
        vecs[6]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1, 16'd2};
        vecs[7]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1, 16'd3};
        vecs[8]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b1, 8'hB1, 2'd1, 1'b1, 16'd3};
        vecs[9]  = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1, 16'd4};
        vecs[10] = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b1, 8'hC2, 2'd2, 1'b1, 16'd4};
        vecs[11] = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1, 16'd5};
        vecs[12] = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        // backpressure for 5 cycles: output held, no grant
        vecs[13] = '{4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        vecs[14] = '{4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        vecs[15] = '{4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        vecs[16] = '{4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        vecs[17] = '{4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 16'd5};
        // release: grant issued on the same edge as the accept (wrapped to 0)
        vecs[18] = '{4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1, 16'd6};
        vecs[19] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1, 16'd6};
        vecs[20] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd7};
    end

    initial begin
        logic [15:0] cnt0;
        logic [7:0]  r;

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'hFFFF_FFFF;
        out_ready = 1'b0;

        // ---- reset state (requests present, nothing accepted) ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_src",   32'(out_src),   32'h0);
        chk("rst_out_perr",  32'(out_perr),  32'h0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);

        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'h0);
        chk("idle_busy",      32'(busy),      32'h0);

        // ---- table-driven sequence ----
        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].rv;
            req_data  = vecs[i].rd;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].ex_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ex_ov));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].ex_busy));
            chk($sformatf("v%0d_xfer_cnt", i),  32'(xfer_cnt),  32'(vecs[i].ex_cnt));
            chk($sformatf("v%0d_out_perr", i),  32'(out_perr),  32'h0);
            if (vecs[i].ex_ov) begin
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].ex_data));
                chk($sformatf("v%0d_out_src", i),  32'(out_src),  32'(vecs[i].ex_src));
            end
        end

        // ---- asynchronous reset mid-cycle while in OUT ----
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("ar_pre_out_valid", 32'(out_valid), 32'h1);
        chk("ar_pre_out_src",   32'(out_src),   32'h2);
        req_valid = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'h0);
        chk("ar_out_data",  32'(out_data),  32'h0);
        chk("ar_out_src",   32'(out_src),   32'h0);
        chk("ar_xfer_cnt",  32'(xfer_cnt),  32'h0);
        chk("ar_busy",      32'(busy),      32'h0);
        chk("ar_req_ready", 32'(req_ready), 32'h0);

        // ---- reset asserted at the negedge of a LAUNCH cycle ----
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_5C00;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rl_busy_launch", 32'(busy), 32'h1);
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rl_out_valid_a", 32'(out_valid), 32'h0);
        chk("rl_busy",        32'(busy),      32'h0);
        @(posedge clk); #1;
        chk("rl_out_valid_b", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        req_data  = 32'h7700_6600;
        #1;
        chk("rl_first_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        chk("rl_out_valid_c", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        chk("rl_out_valid_d", 32'(out_valid), 32'h1);
        chk("rl_out_data",    32'(out_data),  32'h66);
        chk("rl_out_src",     32'(out_src),   32'h1);
        chk("rl_xfer_cnt",    32'(xfer_cnt),  32'h0);
        @(posedge clk); #1;
        chk("rl_xfer_cnt_1",  32'(xfer_cnt),  32'h1);
        chk("rl_idle_busy",   32'(busy),      32'h0);

`ifdef HCXA_PARITY_EN
        // ---- parity: forced single-bit flip on the captured word ----
        out_ready = 1'b0;
        req_valid = 4'b0001;
        req_data  = 32'h0000_003C;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk); #1;
        force dut.cap_q = 8'h3D;
        @(posedge clk); #1;
        release dut.cap_q;
        chk("par_flip_valid", 32'(out_valid), 32'h1);
        chk("par_flip_perr",  32'(out_perr),  32'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // ---- parity: 256 clean random words ----
        cnt0 = xfer_cnt;
        for (int w = 0; w < 256; w++) begin
            r         = 8'($urandom);
            out_ready = 1'b0;
            req_valid = 4'b0001;
            req_data  = {24'h0, r};
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(posedge clk); #1;
            chk("par_rand_data", 32'(out_data), 32'(r));
            chk("par_rand_perr", 32'(out_perr), 32'h0);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("par_rand_cnt", 32'(xfer_cnt - cnt0), 32'd256);
`else
        cnt0 = 16'h0;
        r    = 8'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
